wb_stage_px: RTL

Parametrised writeback stage: the last pipeline stage after MEM. It commits GPR writes, performs CSR read/write with a configurable CSR access latency, and selects one of NUM_EX prioritised exception sources into ecode/esubcode. It also generates ertn/exception flush and keeps a retired-instruction counter. It drives the WB→ID forwarding bus and the debug trace ports.

---
 rtl/wb_stage_px.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_stage_px.sv
// Writeback stage: commits GPR writes and CSR accesses, and picks the highest-priority exception.
// It also raises ertn/exception flushes, counts retired instructions and drives the WB->ID forwarding and trace ports.
module wb_stage_px #(
  parameter int NUM_EX  = 4,
  parameter int CSR_LAT = 1,
  parameter int RET_W   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_wb_valid,
  output logic                 wb_allowin,
  input  logic                 mem_gr_we,
  input  logic [31:0]          mem_pc,
  input  logic [31:0]          mem_result,
  input  logic [4:0]           mem_dest,
  input  logic                 mem_csr_we,
  input  logic                 mem_csr_re,
  input  logic [13:0]          mem_csr_num,
  input  logic [31:0]          mem_csr_wmask,
  input  logic [31:0]          mem_csr_wvalue,
  input  logic                 mem_ertn,
  input  logic [NUM_EX-1:0]    mem_ex_vec,
  input  logic [NUM_EX*15-1:0] mem_ex_code,
  output logic [37:0]          wb_id_bus,
  output logic [13:0]          csr_num,
  output logic                 csr_re,
  input  logic [31:0]          csr_rvalue,
  output logic                 csr_we,
  output logic [31:0]          csr_wmask,
  output logic [31:0]          csr_wvalue,
  output logic                 ertn_flush,
  output logic                 wb_ex,
  output logic [31:0]          wb_csr_pc,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [RET_W-1:0]     retire_cnt,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  localparam logic [2:0] LAT = 3'(CSR_LAT);

  logic                 wb_valid;
  logic [2:0]           wait_cnt;
  logic                 pl_gr_we;
  logic [31:0]          pl_pc;
  logic [31:0]          pl_result;
  logic [4:0]           pl_dest;
  logic                 pl_csr_we;
  logic                 pl_csr_re;
  logic [13:0]          pl_csr_num;
  logic [31:0]          pl_csr_wmask;
  logic [31:0]          pl_csr_wvalue;
  logic                 pl_ertn;
  logic [NUM_EX-1:0]    pl_ex_vec;
  logic [NUM_EX*15-1:0] pl_ex_code;

  logic        wb_ready_go;
  logic        commit;
  logic        any_ex;
  logic        pl_is_csr;
  logic        flush;
  logic        accept;
  logic        mem_csr_go;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign wb_ready_go = (wait_cnt == 3'd0);
  assign wb_allowin  = ~wb_valid | wb_ready_go;
  assign commit      = wb_valid & wb_ready_go;
  assign any_ex      = |pl_ex_vec;
  assign pl_is_csr   = pl_csr_re | pl_csr_we;
  assign flush       = wb_ex | ertn_flush;
  assign accept      = mem_wb_valid & wb_allowin;
  // Only a fault-free CSR instruction that actually lands in WB pays the access latency.
  assign mem_csr_go  = accept & ~flush & (mem_csr_re | mem_csr_we) & ~(|mem_ex_vec);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (wb_allowin) begin
        wb_valid <= mem_wb_valid;
      end
      if (wb_allowin) begin
        wait_cnt <= mem_csr_go ? LAT : 3'd0;
      end else if (wb_valid && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pl_gr_we      <= mem_gr_we;
      pl_pc         <= mem_pc;
      pl_result     <= mem_result;
      pl_dest       <= mem_dest;
      pl_csr_we     <= mem_csr_we;
      pl_csr_re     <= mem_csr_re;
      pl_csr_num    <= mem_csr_num;
      pl_csr_wmask  <= mem_csr_wmask;
      pl_csr_wvalue <= mem_csr_wvalue;
      pl_ertn       <= mem_ertn;
      pl_ex_vec     <= mem_ex_vec;
      pl_ex_code    <= mem_ex_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      retire_cnt <= '0;
    end else if (commit && !any_ex) begin
      retire_cnt <= retire_cnt + RET_W'(1);
    end
  end

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    wb_ecode    = 6'd0;
    wb_esubcode = 9'd0;
    for (int i = NUM_EX - 1; i >= 0; i--) begin
      if (pl_ex_vec[i]) begin
        {wb_esubcode, wb_ecode} = pl_ex_code[15*i +: 15];
      end
    end
  end

  assign wb_ex      = commit & any_ex;
  assign ertn_flush = commit & pl_ertn & ~any_ex;

  assign rf_we    = commit & pl_gr_we & ~any_ex & (pl_dest != 5'd0);
  assign rf_wdata = pl_is_csr ? csr_rvalue : pl_result;

  assign csr_re     = wb_valid & pl_is_csr & ~any_ex;
  assign csr_we     = commit & pl_csr_we & ~any_ex;
  assign csr_num    = pl_csr_num;
  assign csr_wmask  = pl_csr_wmask;
  assign csr_wvalue = pl_csr_wvalue;

  assign wb_id_bus         = {rf_we, pl_dest, rf_wdata};
  assign wb_csr_pc         = pl_pc;
  assign debug_wb_pc       = pl_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = pl_dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
